pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects, pipeline control states and perf-counter helpers.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  localparam int unsigned CntWidth = 16;
  typedef logic [CntWidth-1:0] perfcnt_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic perfcnt_t sat_inc(input perfcnt_t cnt, input logic en);
    perfcnt_t res;
    res = cnt;
    if (en && (cnt != '1)) res = cnt + perfcnt_t'(1);
    return res;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard status from the datapath and latch controls / status back from pipeline_ctrl.
interface pipeline_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     mem_dreq;
  logic     ex_memread;
  regbits_t ex_wsel;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_jump;
  logic     mem_brtaken;
  logic     mem_halt;

  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     memwb_flush;
  logic     halt;
  perfcnt_t stall_cnt;
  perfcnt_t flush_cnt;

  modport master (
    output ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rs, id_rt, id_jump, mem_brtaken,
           mem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           memwb_flush, halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rs, id_rt, id_jump, mem_brtaken,
           mem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           memwb_flush, halt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: EX-stage load whose destination feeds an ID-stage source.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_memread,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     load_use
);

  // $zero is never a real dependency.
  always_comb begin
    load_use = ex_memread && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with halt drain sequence and saturating perf counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input logic          CLK,
  input logic          nRST,
  pipeline_ctrl_if.slave pif
);

  pipe_state_t state_q, state_d;
  logic        halt_q;
  perfcnt_t    stall_q, flush_q;
  logic        stall_inc, flush_inc;
  logic        load_use;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  hazard_detect u_hazard_detect (
    .ex_memread (pif.ex_memread),
    .ex_wsel    (pif.ex_wsel),
    .id_rs      (pif.id_rs),
    .id_rt      (pif.id_rt),
    .load_use   (load_use)
  );

  always_comb begin
    state_d     = state_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (pif.mem_dreq && !pif.dhit) begin
          stall_inc = 1'b1;
        end else if (pif.mem_halt) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          {ifid_flush, idex_flush, exmem_flush}         = '1;
          state_d = DRAIN;
        end else if (pif.mem_brtaken) begin
          // Redirect squashes everything younger, including any load-use victim.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          {ifid_flush, idex_flush, exmem_flush}         = '1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          {idex_en, exmem_en, memwb_en} = '1;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (!pif.ihit) begin
          {ifid_en, idex_en, exmem_en, memwb_en} = '1;
          ifid_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (pif.id_jump) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          ifid_flush = 1'b1;
          flush_inc  = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
        end
      end
      DRAIN: begin
        memwb_en = 1'b1;
        {ifid_flush, idex_flush, exmem_flush} = '1;
        state_d = HALTED;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d == HALTED);
      stall_q <= sat_inc(stall_q, stall_inc);
      flush_q <= sat_inc(flush_q, flush_inc);
    end
  end

  assign pif.pc_en       = pc_en;
  assign pif.ifid_en     = ifid_en;
  assign pif.idex_en     = idex_en;
  assign pif.exmem_en    = exmem_en;
  assign pif.memwb_en    = memwb_en;
  assign pif.ifid_flush  = ifid_flush;
  assign pif.idex_flush  = idex_flush;
  assign pif.exmem_flush = exmem_flush;
  assign pif.memwb_flush = memwb_flush;
  assign pif.halt        = halt_q;
  assign pif.stall_cnt   = stall_q;
  assign pif.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes model expectations, monitor checks at negedge.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       mem_dreq;
    logic       ex_memread;
    logic [4:0] ex_wsel;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_jump;
    logic       mem_brtaken;
    logic       mem_halt;
  } stim_t;

  // ctl = {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  typedef struct packed {
    logic [8:0]  ctl;
    logic        halt;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  localparam logic [8:0] CtlFreeze = 9'b00000_0000;
  localparam logic [8:0] CtlRedir  = 9'b11111_1110;
  localparam logic [8:0] CtlLdUse  = 9'b00111_0100;
  localparam logic [8:0] CtlIMiss  = 9'b01111_1000;
  localparam logic [8:0] CtlJump   = 9'b11111_1000;
  localparam logic [8:0] CtlNormal = 9'b11111_0000;
  localparam logic [8:0] CtlDrain  = 9'b00001_1110;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  pipeline_ctrl_if pif ();

  pipeline_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .pif  (pif)
  );

  always #5 CLK = ~CLK;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: 0 running, 1 draining, 2 halted.
  int   m_mode  = 0;
  bit   m_halt  = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.ihit        = ($urandom_range(0, 3) != 0);
    s.dhit        = $urandom_range(0, 1) == 1;
    s.mem_dreq    = ($urandom_range(0, 9) < 3);
    s.ex_memread  = ($urandom_range(0, 9) < 3);
    s.ex_wsel     = 5'($urandom_range(0, 3));
    s.id_rs       = 5'($urandom_range(0, 3));
    s.id_rt       = 5'($urandom_range(0, 3));
    s.id_jump     = ($urandom_range(0, 4) == 0);
    s.mem_brtaken = ($urandom_range(0, 6) == 0);
    s.mem_halt    = ($urandom_range(0, 39) == 0);
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic step(input stim_t s, input bit rst);
    exp_t       e;
    logic [8:0] ctl;
    int         nxt;
    bit         lu;
    bit         st_inc;
    bit         fl_inc;
    @(posedge CLK);
    #1;
    nRST            = !rst;
    pif.ihit        = s.ihit;
    pif.dhit        = s.dhit;
    pif.mem_dreq    = s.mem_dreq;
    pif.ex_memread  = s.ex_memread;
    pif.ex_wsel     = s.ex_wsel;
    pif.id_rs       = s.id_rs;
    pif.id_rt       = s.id_rt;
    pif.id_jump     = s.id_jump;
    pif.mem_brtaken = s.mem_brtaken;
    pif.mem_halt    = s.mem_halt;
    if (rst) begin
      m_mode  = 0;
      m_halt  = 1'b0;
      m_stall = 0;
      m_flush = 0;
    end
    lu     = s.ex_memread && (s.ex_wsel != 0) && (s.ex_wsel == s.id_rs || s.ex_wsel == s.id_rt);
    nxt    = m_mode;
    st_inc = 1'b0;
    fl_inc = 1'b0;
    ctl    = CtlFreeze;
    if (m_mode == 0) begin
      if (s.mem_dreq && !s.dhit)  begin ctl = CtlFreeze; st_inc = 1'b1; end
      else if (s.mem_halt)        begin ctl = CtlRedir;  nxt = 1; end
      else if (s.mem_brtaken)     begin ctl = CtlRedir;  fl_inc = 1'b1; end
      else if (lu)                begin ctl = CtlLdUse;  st_inc = 1'b1; end
      else if (!s.ihit)           begin ctl = CtlIMiss;  st_inc = 1'b1; end
      else if (s.id_jump)         begin ctl = CtlJump;   fl_inc = 1'b1; end
      else                        begin ctl = CtlNormal; end
    end else if (m_mode == 1) begin
      ctl = CtlDrain;
      nxt = 2;
    end
    e.ctl   = ctl;
    e.halt  = m_halt;
    e.stall = 16'(m_stall);
    e.flush = 16'(m_flush);
    sb.push_back(e);
    if (!rst) begin
      m_mode  = nxt;
      m_halt  = (nxt == 2);
      m_stall = sat(m_stall + int'(st_inc));
      m_flush = sat(m_flush + int'(fl_inc));
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t       e;
    logic [8:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
             pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush};
      n_vec++;
      if (act !== e.ctl) begin
        n_err++;
        $display("FAIL ctl @%0t: got %b want %b", $time, act, e.ctl);
      end
      n_vec++;
      if (pif.halt !== e.halt) begin
        n_err++;
        $display("FAIL halt @%0t: got %b want %b", $time, pif.halt, e.halt);
      end
      n_vec++;
      if ({pif.stall_cnt, pif.flush_cnt} !== {e.stall, e.flush}) begin
        n_err++;
        $display("FAIL counters @%0t: got stall %0d flush %0d want stall %0d flush %0d",
                 $time, pif.stall_cnt, pif.flush_cnt, e.stall, e.flush);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle_stim();
    step(s, 1'b1);
    step(s, 1'b1);
    step(s, 1'b0);

    // Load-use stall then an idle cycle to observe stall_cnt.
    s = idle_stim(); s.ex_memread = 1'b1; s.ex_wsel = 5'd8; s.id_rs = 5'd8;
    step(s, 1'b0);
    step(idle_stim(), 1'b0);

    // Data miss with a pending redirect, then the hit cycle.
    s = idle_stim(); s.mem_dreq = 1'b1; s.dhit = 1'b0; s.mem_brtaken = 1'b1;
    for (int i = 0; i < 3; i++) step(s, 1'b0);
    s.dhit = 1'b1;
    step(s, 1'b0);

    // Jump under fetch miss, then jump with hit.
    s = idle_stim(); s.id_jump = 1'b1; s.ihit = 1'b0;
    step(s, 1'b0);
    s.ihit = 1'b1;
    step(s, 1'b0);

    // $zero destination never stalls; branch wins over load-use.
    s = idle_stim(); s.ex_memread = 1'b1; s.ex_wsel = 5'd0; s.id_rs = 5'd0; s.id_rt = 5'd0;
    step(s, 1'b0);
    s = idle_stim(); s.ex_memread = 1'b1; s.ex_wsel = 5'd5; s.id_rt = 5'd5; s.mem_brtaken = 1'b1;
    step(s, 1'b0);

    // Halt, drain, then held while inputs toggle.
    s = idle_stim(); s.mem_halt = 1'b1;
    step(s, 1'b0);
    step(idle_stim(), 1'b0);
    for (int i = 0; i < 11; i++) begin
      s = rand_stim(); s.ihit = i[0];
      step(s, 1'b0);
    end

    // Reset asserted mid-cycle while draining.
    step(idle_stim(), 1'b1);
    step(idle_stim(), 1'b0);
    s = idle_stim(); s.mem_halt = 1'b1;
    step(s, 1'b0);
    step(idle_stim(), 1'b1);
    step(idle_stim(), 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        step(rand_stim(), 1'b1);
      else
        step(rand_stim(), 1'b0);
    end

    // Stall counter saturation.
    step(idle_stim(), 1'b1);
    s = idle_stim(); s.ihit = 1'b0;
    for (int i = 0; i < 65540; i++) step(s, 1'b0);
    step(idle_stim(), 1'b0);

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
